// File: rtl/mem_access_pkg.sv
// mem_access_pkg
//   Shared definitions for the memory-access stage: load/store funct3 codes,
//   byte-enable width, FSM state encoding, default ack timeout, and helpers
//   for store lane placement and alignment checks.
package mem_access_pkg;

    localparam int MEM_BE_W    = 4;
    localparam int TIMEOUT_DEF = 16;

    // load funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    // store funct3
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    function automatic logic [MEM_BE_W-1:0] store_be(input logic [2:0] f3,
                                                     input logic [1:0] off);
        case (f3)
            F3_SB:   store_be = 4'b0001 << off;
            F3_SH:   store_be = off[1] ? 4'b1100 : 4'b0011;
            F3_SW:   store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
    endfunction

    // Replicate the store operand into every lane it could land in.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3,
                                                input logic [31:0] d);
        case (f3)
            F3_SB:   store_wdata = {4{d[7:0]}};
            F3_SH:   store_wdata = {2{d[15:0]}};
            default: store_wdata = d;
        endcase
    endfunction

    // Load and store share the size encoding in funct3, so one check covers both.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        if (f3 == F3_LH || f3 == F3_LHU) misaligned = off[0];
        else if (f3 == F3_LW)            misaligned = |off;
        else                             misaligned = 1'b0;
    endfunction

endpackage

// File: rtl/mem_load_fmt.sv
// mem_load_fmt
//   Selects the addressed byte/halfword of a read word and sign/zero extends.
//   i_rdata  : 32-bit word returned by data memory
//   i_off    : byte offset addr[1:0]
//   i_funct3 : load type; undefined codes give 0
//   o_data   : extended 32-bit result
module mem_load_fmt
    import mem_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = '0;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LW:   o_data = i_rdata;
            F3_LBU:  o_data = {24'd0, w_byte};
            F3_LHU:  o_data = {16'd0, w_half};
            default: o_data = '0;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// mem_access
//   Memory-access pipeline stage. Passes ALU results to wb with one cycle of
//   latency, runs loads/stores on a req/ack data-memory port, formats load
//   data, and stalls earlier stages while a transaction is outstanding.
//   Misaligned accesses are dropped with a misalign_o pulse; a request that
//   sees no ack for TIMEOUT cycles is abandoned with a bus_err_o pulse.
//   Inputs : clk, arst_n (sync, active-low), inst_i, reg_w_*_i, mem_r_*_i,
//            mem_w_*_i, forwardC_i, dmem_ack_i, dmem_rdata_i
//   Outputs: dmem_req/we/addr/be/wdata_o, stall_o, misalign_o, bus_err_o,
//            reg_w_ena/addr/data_o, forwardC_o
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)(
    input  logic                clk,
    input  logic                arst_n,
    input  logic [31:0]         inst_i,
    input  logic                reg_w_ena_i,
    input  logic [4:0]          reg_w_addr_i,
    input  logic [31:0]         reg_w_data_i,
    input  logic                mem_r_ena_i,
    input  logic [31:0]         mem_r_addr_i,
    input  logic                mem_w_ena_i,
    input  logic [31:0]         mem_w_addr_i,
    input  logic                forwardC_i,
    output logic                dmem_req_o,
    output logic                dmem_we_o,
    output logic [31:0]         dmem_addr_o,
    output logic [MEM_BE_W-1:0] dmem_be_o,
    output logic [31:0]         dmem_wdata_o,
    input  logic                dmem_ack_i,
    input  logic [31:0]         dmem_rdata_i,
    output logic                stall_o,
    output logic                misalign_o,
    output logic                bus_err_o,
    output logic                reg_w_ena_o,
    output logic [4:0]          reg_w_addr_o,
    output logic [31:0]         reg_w_data_o,
    output logic                forwardC_o
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dm_we;
    logic [31:0]        r_dm_addr, r_dm_wdata;
    logic [MEM_BE_W-1:0] r_dm_be;
    logic [2:0]         r_f3;
    logic [1:0]         r_off;
    logic               r_rd_ena, r_fwd;
    logic [4:0]         r_rd_addr;
    logic               r_reg_w_ena, r_fwd_o, r_misalign;
    logic [4:0]         r_reg_w_addr;
    logic [31:0]        r_reg_w_data;

    logic        w_is_store, w_mem_op, w_misal, w_tmo_hit;
    logic        w_launch, w_done, w_tmo, w_drop, w_stall;
    logic [2:0]  w_f3;
    logic [31:0] w_addr, w_ld_data;
    logic        w_unused;

    // Only funct3 matters here; the op type comes from the enables.
    assign w_unused   = ^{inst_i[31:15], inst_i[11:0]};
    assign w_f3       = inst_i[14:12];
    assign w_is_store = mem_w_ena_i;            // both enables high -> store
    assign w_mem_op   = mem_r_ena_i | mem_w_ena_i;
    assign w_addr     = w_is_store ? mem_w_addr_i : mem_r_addr_i;
    assign w_misal    = misaligned(w_f3, w_addr[1:0]);
    assign w_tmo_hit  = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        w_drop      = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_op) begin
                    if (w_misal) begin
                        w_drop = 1'b1;
                    end else begin
                        w_launch    = 1'b1;
                        w_stall     = 1'b1;
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // ack takes priority over a coincident timeout
                if (dmem_ack_i) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_tmo_hit) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    mem_load_fmt u_fmt (
        .i_rdata  (dmem_rdata_i),
        .i_off    (r_off),
        .i_funct3 (r_f3),
        .o_data   (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_dm_we      <= 1'b0;
            r_dm_addr    <= '0;
            r_dm_be      <= '0;
            r_dm_wdata   <= '0;
            r_f3         <= '0;
            r_off        <= '0;
            r_rd_ena     <= 1'b0;
            r_rd_addr    <= '0;
            r_fwd        <= 1'b0;
            r_reg_w_ena  <= 1'b0;
            r_reg_w_addr <= '0;
            r_reg_w_data <= '0;
            r_fwd_o      <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_misalign <= w_drop;
            r_cnt      <= (r_state == ST_REQ && w_state_nxt == ST_REQ) ? r_cnt + CNT_W'(1) : '0;

            if (w_launch) begin
                r_dm_we     <= w_is_store;
                r_dm_addr   <= {w_addr[31:2], 2'b00};
                r_dm_be     <= w_is_store ? store_be(w_f3, w_addr[1:0]) : 4'b1111;
                r_dm_wdata  <= store_wdata(w_f3, reg_w_data_i);
                r_f3        <= w_f3;
                r_off       <= w_addr[1:0];
                r_rd_ena    <= reg_w_ena_i;
                r_rd_addr   <= reg_w_addr_i;
                r_fwd       <= forwardC_i;
                r_reg_w_ena <= 1'b0;        // bubble to wb while the bus runs
            end else if (r_state == ST_IDLE) begin
                r_reg_w_ena  <= reg_w_ena_i & ~w_drop;
                r_reg_w_addr <= reg_w_addr_i;
                r_reg_w_data <= reg_w_data_i;
                r_fwd_o      <= forwardC_i;
            end else if (w_done) begin
                r_reg_w_ena  <= r_rd_ena & ~r_dm_we;
                r_reg_w_addr <= r_rd_addr;
                r_fwd_o      <= r_fwd;
                if (!r_dm_we) r_reg_w_data <= w_ld_data;
            end else begin
                r_reg_w_ena <= 1'b0;
                if (w_tmo) r_fwd_o <= r_fwd;
            end
        end
    end

    // Gate the combinational handshakes so everything reads 0 while in reset.
    assign stall_o      = w_stall & arst_n;
    assign bus_err_o    = w_tmo & arst_n;
    assign dmem_req_o   = (r_state == ST_REQ);
    assign dmem_we_o    = r_dm_we;
    assign dmem_addr_o  = r_dm_addr;
    assign dmem_be_o    = r_dm_be;
    assign dmem_wdata_o = r_dm_wdata;
    assign misalign_o   = r_misalign;
    assign reg_w_ena_o  = r_reg_w_ena;
    assign reg_w_addr_o = r_reg_w_addr;
    assign reg_w_data_o = r_reg_w_data;
    assign forwardC_o   = r_fwd_o;
endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
    logic        clk = 1'b0;
    logic        arst_n;
    logic [31:0] inst_i;
    logic        reg_w_ena_i;
    logic [4:0]  reg_w_addr_i;
    logic [31:0] reg_w_data_i;
    logic        mem_r_ena_i;
    logic [31:0] mem_r_addr_i;
    logic        mem_w_ena_i;
    logic [31:0] mem_w_addr_i;
    logic        forwardC_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o, misalign_o, bus_err_o;
    logic        reg_w_ena_o;
    logic [4:0]  reg_w_addr_o;
    logic [31:0] reg_w_data_o;
    logic        forwardC_o;

    int n_chk  = 0;
    int n_fail = 0;

    mem_access #(.TIMEOUT(16)) dut (
        .clk(clk), .arst_n(arst_n), .inst_i(inst_i),
        .reg_w_ena_i(reg_w_ena_i), .reg_w_addr_i(reg_w_addr_i), .reg_w_data_i(reg_w_data_i),
        .mem_r_ena_i(mem_r_ena_i), .mem_r_addr_i(mem_r_addr_i),
        .mem_w_ena_i(mem_w_ena_i), .mem_w_addr_i(mem_w_addr_i),
        .forwardC_i(forwardC_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .reg_w_ena_o(reg_w_ena_o), .reg_w_addr_o(reg_w_addr_o), .reg_w_data_o(reg_w_data_o),
        .forwardC_o(forwardC_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        inst_i = 32'h0000_0013; reg_w_ena_i = 1'b0; reg_w_addr_i = '0; reg_w_data_i = '0;
        mem_r_ena_i = 1'b0; mem_r_addr_i = '0; mem_w_ena_i = 1'b0; mem_w_addr_i = '0;
        forwardC_i = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    endtask

    task automatic drive_mem(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] data, input logic rde, input logic [4:0] rd);
        inst_i       = {17'd0, f3, 5'd0, st ? 7'b0100011 : 7'b0000011};
        reg_w_ena_i  = rde; reg_w_addr_i = rd; reg_w_data_i = data;
        mem_r_ena_i  = ~st; mem_r_addr_i = addr;
        mem_w_ena_i  = st;  mem_w_addr_i = addr;
    endtask

    task automatic test_reset;
        drive_idle(); arst_n = 1'b0;
        tick(); tick();
        n_chk++;
        if ({dmem_req_o, stall_o, misalign_o, bus_err_o, reg_w_ena_o, reg_w_addr_o, reg_w_data_o, forwardC_o} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: req=%b stall=%b ena=%b data=%h, want all 0",
                               dmem_req_o, stall_o, reg_w_ena_o, reg_w_data_o);
        end
        arst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu;
        drive_idle();
        inst_i = 32'h0050_0193; reg_w_ena_i = 1'b1; reg_w_addr_i = 5'd3; reg_w_data_i = 32'h5;
        forwardC_i = 1'b1;
        #1;
        n_chk++;
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b want 0", stall_o); end
        tick();
        drive_idle();
        n_chk++;
        if ({reg_w_ena_o, reg_w_addr_o, reg_w_data_o, forwardC_o} !== {1'b1, 5'd3, 32'h5, 1'b1}) begin
            n_fail++; $display("FAIL alu_wb: got ena=%b rd=%0d data=%h fwd=%b want 1/3/00000005/1",
                               reg_w_ena_o, reg_w_addr_o, reg_w_data_o, forwardC_o);
        end
    endtask

    task automatic test_lb;
        int stall_cycles = 0;
        logic req_ok = 1'b1;
        drive_mem(1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 5'd7);
        #1; if (stall_o) stall_cycles++;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) begin dmem_ack_i = 1'b1; dmem_rdata_i = 32'h80FF_FF7F; end
            #1;
            if (stall_o) stall_cycles++;
            if (!(dmem_req_o === 1'b1 && dmem_addr_o === 32'h100 && dmem_be_o === 4'hF && dmem_we_o === 1'b0))
                req_ok = 1'b0;
        end
        n_chk++;
        if (req_ok !== 1'b1) begin
            n_fail++; $display("FAIL lb_req_hold: got req=%b addr=%h be=%h we=%b want 1/00000100/f/0",
                               dmem_req_o, dmem_addr_o, dmem_be_o, dmem_we_o);
        end
        n_chk++;
        if (stall_o !== 1'b0) begin n_fail++; $display("FAIL lb_ack_stall: got %b want 0", stall_o); end
        tick();
        drive_idle();
        n_chk++;
        if (stall_cycles != 3) begin n_fail++; $display("FAIL lb_stall_len: got %0d want 3", stall_cycles); end
        n_chk++;
        if ({reg_w_ena_o, reg_w_addr_o, reg_w_data_o, dmem_req_o} !== {1'b1, 5'd7, 32'hFFFF_FF80, 1'b0}) begin
            n_fail++; $display("FAIL lb_wb: got ena=%b rd=%0d data=%h req=%b want 1/7/ffffff80/0",
                               reg_w_ena_o, reg_w_addr_o, reg_w_data_o, dmem_req_o);
        end
    endtask

    task automatic test_stores;
        logic [2:0]  f3s[2]  = '{3'b001, 3'b000};
        logic [31:0] adr[2]  = '{32'h102, 32'h203};
        logic [31:0] dat[2]  = '{32'h1234_ABCD, 32'hAABB_CC77};
        logic [31:0] ewa[2]  = '{32'hABCD_ABCD, 32'h7777_7777};
        logic [31:0] ead[2]  = '{32'h100, 32'h200};
        logic [3:0]  ebe[2]  = '{4'b1100, 4'b1000};
        for (int i = 0; i < 2; i++) begin
            drive_mem(1'b1, f3s[i], adr[i], dat[i], 1'b1, 5'd4);
            tick();
            dmem_ack_i = 1'b1;
            #1;
            n_chk++;
            if ({dmem_req_o, dmem_we_o, dmem_be_o, dmem_wdata_o, dmem_addr_o, stall_o} !==
                {1'b1, 1'b1, ebe[i], ewa[i], ead[i], 1'b0}) begin
                n_fail++; $display("FAIL store_bus[%0d]: got req=%b we=%b be=%b wdata=%h addr=%h stall=%b want 1/1/%b/%h/%h/0",
                                   i, dmem_req_o, dmem_we_o, dmem_be_o, dmem_wdata_o, dmem_addr_o, stall_o,
                                   ebe[i], ewa[i], ead[i]);
            end
            tick();
            drive_idle();
            n_chk++;
            if ({reg_w_ena_o, dmem_req_o} !== 2'b00) begin
                n_fail++; $display("FAIL store_wb[%0d]: got ena=%b req=%b want 0/0", i, reg_w_ena_o, dmem_req_o);
            end
        end
    endtask

    task automatic test_load_formats;
        logic [2:0]  f3s[5] = '{3'b001, 3'b101, 3'b100, 3'b010, 3'b011};
        logic [31:0] adr[5] = '{32'h102, 32'h102, 32'h101, 32'h104, 32'h108};
        logic [31:0] rdt[5] = '{32'h8001_1234, 32'h8001_1234, 32'h0000_9A00, 32'h1234_5678, 32'hFFFF_FFFF};
        logic [31:0] exp[5] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_009A, 32'h1234_5678, 32'h0};
        for (int i = 0; i < 5; i++) begin
            drive_mem(1'b0, f3s[i], adr[i], 32'h0, 1'b1, 5'd10);
            tick();
            dmem_ack_i = 1'b1; dmem_rdata_i = rdt[i];
            tick();
            drive_idle();
            n_chk++;
            if (reg_w_data_o !== exp[i]) begin
                n_fail++; $display("FAIL load_fmt[%0d]: got %h want %h", i, reg_w_data_o, exp[i]);
            end
        end
    endtask

    task automatic test_misalign;
        drive_mem(1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 5'd8);
        #1;
        n_chk++;
        if ({stall_o, dmem_req_o} !== 2'b00) begin
            n_fail++; $display("FAIL misalign_stall: got stall=%b req=%b want 0/0", stall_o, dmem_req_o);
        end
        tick();
        drive_idle();
        n_chk++;
        if ({misalign_o, reg_w_ena_o, dmem_req_o} !== 3'b100) begin
            n_fail++; $display("FAIL misalign_pulse: got mis=%b ena=%b req=%b want 1/0/0",
                               misalign_o, reg_w_ena_o, dmem_req_o);
        end
        tick();
        n_chk++;
        if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got %b want 0", misalign_o); end
    endtask

    task automatic test_timeout;
        int   err_cyc = 0;
        logic st_at   = 1'b1;
        drive_mem(1'b0, 3'b010, 32'h200, 32'h0, 1'b1, 5'd11);
        tick();
        for (int k = 1; k <= 20 && err_cyc == 0; k++) begin
            #1;
            if (bus_err_o === 1'b1) begin err_cyc = k; st_at = stall_o; end
            tick();
        end
        drive_idle();
        n_chk++;
        if (err_cyc != 16) begin n_fail++; $display("FAIL timeout_cycle: got %0d want 16", err_cyc); end
        n_chk++;
        if (st_at !== 1'b0) begin n_fail++; $display("FAIL timeout_stall: got %b want 0", st_at); end
        n_chk++;
        if ({reg_w_ena_o, dmem_req_o, bus_err_o} !== 3'b000) begin
            n_fail++; $display("FAIL timeout_after: got ena=%b req=%b err=%b want 0/0/0",
                               reg_w_ena_o, dmem_req_o, bus_err_o);
        end
    endtask

    task automatic test_ack_at_timeout;
        logic early = 1'b0;
        drive_mem(1'b0, 3'b010, 32'h204, 32'h0, 1'b1, 5'd12);
        tick();
        for (int k = 1; k <= 15; k++) begin
            #1;
            if (bus_err_o !== 1'b0 || stall_o !== 1'b1) early = 1'b1;
            tick();
        end
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
        #1;
        n_chk++;
        if ({early, bus_err_o, stall_o} !== 3'b000) begin
            n_fail++; $display("FAIL ack_tmo_cycle: got early=%b err=%b stall=%b want 0/0/0",
                               early, bus_err_o, stall_o);
        end
        tick();
        drive_idle();
        n_chk++;
        if ({reg_w_ena_o, reg_w_addr_o, reg_w_data_o} !== {1'b1, 5'd12, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL ack_tmo_wb: got ena=%b rd=%0d data=%h want 1/12/deadbeef",
                               reg_w_ena_o, reg_w_addr_o, reg_w_data_o);
        end
    endtask

    task automatic test_reset_mid;
        drive_mem(1'b0, 3'b010, 32'h300, 32'h0, 1'b1, 5'd9);
        tick();
        tick();
        arst_n = 1'b0;
        drive_idle();
        tick();
        n_chk++;
        if ({dmem_req_o, stall_o, reg_w_ena_o, reg_w_data_o, bus_err_o, misalign_o} !== '0) begin
            n_fail++; $display("FAIL reset_mid: got req=%b stall=%b ena=%b data=%h want 0",
                               dmem_req_o, stall_o, reg_w_ena_o, reg_w_data_o);
        end
        arst_n = 1'b1;
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
        tick();
        drive_idle();
        n_chk++;
        if ({reg_w_ena_o, reg_w_data_o, dmem_req_o} !== '0) begin
            n_fail++; $display("FAIL late_ack: got ena=%b data=%h req=%b want 0",
                               reg_w_ena_o, reg_w_data_o, dmem_req_o);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        arst_n = 1'b0;
        drive_idle();
        test_reset();
        test_alu();
        test_lb();
        test_stores();
        test_load_formats();
        test_misalign();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
